// File: rtl/adder_input_packer.sv
// rtl/adder_input_packer.sv - packs a byte stream into 8-lane vectors for pipelined_adder
// Optional short-frame zero padding on s_last is enabled by defining PACKER_LAST_PAD_EN.
module adder_input_packer #(
   parameter int SUM_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             s_last,
   input  logic             freeze,
   output logic [7:0]       lane0,
   output logic [7:0]       lane1,
   output logic [7:0]       lane2,
   output logic [7:0]       lane3,
   output logic [7:0]       lane4,
   output logic [7:0]       lane5,
   output logic [7:0]       lane6,
   output logic [7:0]       lane7,
   output logic             launch,
   output logic             sum_valid,
   output logic [2:0]       fill,
   output logic [CNT_W-1:0] vec_count
);

   typedef enum logic {FILL, COMMIT} state_t;

   state_t             state_q, state_d;
   logic               rst_q;
   logic [6:0][7:0]    buf_q, buf_d;
   logic [7:0][7:0]    lane_q, lane_d;
   logic [2:0]         fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SUM_LAT-1:0] pipe_q;
   logic               accept;
   logic               commit;

   // Held low through reset and the first cycle after it.
   assign s_ready = !freeze && !rst_q && !rst;
   assign accept  = s_valid && s_ready;

`ifdef PACKER_LAST_PAD_EN
   assign commit = accept && ((fill_q == 3'd7) || s_last);
`else
   logic unused_s_last;
   assign unused_s_last = s_last;
   assign commit = accept && (fill_q == 3'd7);
`endif

   always_comb begin
      state_d = FILL;
      buf_d   = buf_q;
      lane_d  = lane_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      if (accept) begin
         fill_d = fill_q + 3'd1;
         for (int i = 0; i < 7; i++) begin
            if (fill_q == 3'(i)) buf_d[i] = s_data;
         end
      end
      // Lanes below fill come from buf, the lane at fill from s_data, lanes above are zero.
      if (commit) begin
         state_d = COMMIT;
         fill_d  = 3'd0;
         cnt_d   = cnt_q + CNT_W'(1);
         for (int i = 0; i < 7; i++) begin
            if (3'(i) < fill_q)       lane_d[i] = buf_q[i];
            else if (3'(i) == fill_q) lane_d[i] = s_data;
            else                      lane_d[i] = 8'd0;
         end
         lane_d[7] = (fill_q == 3'd7) ? s_data : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      rst_q <= rst;
      if (rst) begin
         state_q <= FILL;
         buf_q   <= '0;
         lane_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         lane_q  <= lane_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         pipe_q  <= (pipe_q << 1) | SUM_LAT'(state_q == COMMIT);
      end
   end

   assign launch    = (state_q == COMMIT);
   assign sum_valid = pipe_q[SUM_LAT-1];
   assign fill      = fill_q;
   assign vec_count = cnt_q;
   assign lane0     = lane_q[0];
   assign lane1     = lane_q[1];
   assign lane2     = lane_q[2];
   assign lane3     = lane_q[3];
   assign lane4     = lane_q[4];
   assign lane5     = lane_q[5];
   assign lane6     = lane_q[6];
   assign lane7     = lane_q[7];

endmodule

// File: tb/tb_adder_input_packer.sv
// tb/tb_adder_input_packer.sv - randomized self-checking bench for adder_input_packer
module tb_adder_input_packer;
   localparam int SUM_LAT = 3;
   localparam int CNT_W   = 16;
`ifdef PACKER_LAST_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] s_data = 8'd0;
   logic s_valid = 1'b0, s_last = 1'b0, freeze = 1'b0;
   logic s_ready, launch, sum_valid;
   logic [7:0] lane0, lane1, lane2, lane3, lane4, lane5, lane6, lane7;
   logic [2:0] fill;
   logic [CNT_W-1:0] vec_count;
   logic [63:0] dut_lanes;

   adder_input_packer #(.SUM_LAT(SUM_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .s_last(s_last), .freeze(freeze),
      .lane0(lane0), .lane1(lane1), .lane2(lane2), .lane3(lane3),
      .lane4(lane4), .lane5(lane5), .lane6(lane6), .lane7(lane7),
      .launch(launch), .sum_valid(sum_valid), .fill(fill), .vec_count(vec_count)
   );

   always #5 clk = ~clk;
   assign dut_lanes = {lane7, lane6, lane5, lane4, lane3, lane2, lane1, lane0};

   typedef struct packed { logic [31:0] cyc; logic [63:0] v; } ev_t;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   ev_t exp_l[$], obs_l[$], exp_s[$], obs_s[$], due_q[$];
   logic [7:0] m_bytes[$];
   logic m_rst_q = 1'b1;
   logic m_acc = 1'b0;
   int m_count = 0;

   function automatic int lane_sum();
      return (int'(lane0) + int'(lane1) + int'(lane2) + int'(lane3) +
              int'(lane4) + int'(lane5) + int'(lane6) + int'(lane7)) % 256;
   endfunction

   // Reference model: a frame is the list of accepted bytes, zero-padded to 8 lanes;
   // its sum is flagged SUM_LAT cycles after the launch cycle unless a reset intervenes.
   task automatic tick();
      ev_t e;
      int s;
      m_acc = s_valid && !freeze && !rst && !m_rst_q;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_bytes.delete();
         due_q.delete();
         m_count = 0;
      end else if (m_acc) begin
         m_bytes.push_back(s_data);
         if (m_bytes.size() == 8 || (PAD && s_last)) begin
            e.v = '0;
            s = 0;
            foreach (m_bytes[i]) begin
               e.v[i*8 +: 8] = m_bytes[i];
               s += int'(m_bytes[i]);
            end
            e.cyc = cyc;
            exp_l.push_back(e);
            e.cyc = cyc + SUM_LAT;
            e.v = 64'(s % 256);
            due_q.push_back(e);
            m_count = (m_count + 1) % (1 << CNT_W);
            m_bytes.delete();
         end
      end
      m_rst_q = rst;
      while (due_q.size() > 0 && int'(due_q[0].cyc) == cyc) exp_s.push_back(due_q.pop_front());
      #1;
      if (launch === 1'b1) begin
         e.cyc = cyc; e.v = dut_lanes; obs_l.push_back(e);
      end
      if (sum_valid === 1'b1) begin
         e.cyc = cyc; e.v = 64'(lane_sum()); obs_s.push_back(e);
      end
   endtask

   task automatic send_byte(input logic [7:0] d, input logic last);
      int k = 0;
      s_valid = 1'b1; s_data = d; s_last = last;
      do begin
         tick();
         k++;
      end while (!m_acc && k < 20);
      s_valid = 1'b0; s_last = 1'b0;
      if (!m_acc) begin
         n_checks++;
         $display("FAIL send_timeout: byte %0d not accepted within 20 cycles", d);
      end
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic clear_events();
      exp_l.delete(); obs_l.delete(); exp_s.delete(); obs_s.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; freeze = 1'b0;
      tick();
      n_checks++;
      if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b expected 0", s_ready); else n_pass++;
      tick();
      n_checks++;
      if (dut_lanes !== 64'd0) $display("FAIL reset_lanes: got %h expected 0", dut_lanes); else n_pass++;
      n_checks++;
      if (launch !== 1'b0 || sum_valid !== 1'b0)
         $display("FAIL reset_strobes: got launch %b sum_valid %b expected 0 0", launch, sum_valid);
      else n_pass++;
      n_checks++;
      if (fill !== 3'd0 || vec_count !== '0)
         $display("FAIL reset_counts: got fill %0d vec_count %0d expected 0 0", fill, vec_count);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (s_ready !== 1'b0) $display("FAIL post_reset_ready: got %b expected 0", s_ready); else n_pass++;
      tick();
      n_checks++;
      if (s_ready !== 1'b1) $display("FAIL ready_release: got %b expected 1", s_ready); else n_pass++;
   endtask

   task automatic test_full_vector();
      ev_t lo, so;
      clear_events();
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
      idle(6);
      lo = (obs_l.size() > 0) ? obs_l[0] : '1;
      so = (obs_s.size() > 0) ? obs_s[0] : '1;
      n_checks++;
      if (obs_l.size() != 1 || lo.v !== 64'h0807060504030201)
         $display("FAIL full_lanes: got %0d launches lanes %h expected 1 lanes 0807060504030201", obs_l.size(), lo.v);
      else n_pass++;
      n_checks++;
      if (exp_l.size() != 1 || lo.cyc !== exp_l[0].cyc)
         $display("FAIL full_launch_cycle: got %0d expected %0d", lo.cyc, (exp_l.size() > 0) ? exp_l[0].cyc : 0);
      else n_pass++;
      n_checks++;
      if (obs_s.size() != 1 || so.v !== 64'd36 || so.cyc !== lo.cyc + SUM_LAT)
         $display("FAIL full_sum: got %0d pulses sum %0d at +%0d expected 1 sum 36 at +%0d",
                  obs_s.size(), so.v, so.cyc - lo.cyc, SUM_LAT);
      else n_pass++;
      n_checks++;
      if (vec_count !== CNT_W'(1)) $display("FAIL full_vec_count: got %0d expected 1", vec_count); else n_pass++;
   endtask

   task automatic test_back_to_back();
      ev_t l1, s0, s1;
      clear_events();
      for (int i = 1; i <= 8; i++) send_byte(8'(i * 10), 1'b0);
      for (int i = 0; i < 8; i++) send_byte(8'd255, 1'b0);
      idle(6);
      l1 = (obs_l.size() > 1) ? obs_l[1] : '1;
      s0 = (obs_s.size() > 0) ? obs_s[0] : '1;
      s1 = (obs_s.size() > 1) ? obs_s[1] : '1;
      n_checks++;
      if (obs_l.size() != 2 || l1.cyc - obs_l[0].cyc != 8)
         $display("FAIL b2b_launches: got %0d launches expected 2 spaced 8 cycles", obs_l.size());
      else n_pass++;
      n_checks++;
      if (obs_s.size() != 2 || s0.v !== 64'd104 || s1.v !== 64'd248)
         $display("FAIL b2b_sums: got %0d pulses sums %0d %0d expected 2 sums 104 248", obs_s.size(), s0.v, s1.v);
      else n_pass++;
      n_checks++;
      if (obs_s.size() != exp_s.size() || s1 !== ((exp_s.size() > 1) ? exp_s[1] : '0))
         $display("FAIL b2b_sum_timing: got %0d pulses last at %0d expected %0d pulses", obs_s.size(), s1.cyc, exp_s.size());
      else n_pass++;
      n_checks++;
      if (vec_count !== CNT_W'(m_count)) $display("FAIL b2b_vec_count: got %0d expected %0d", vec_count, m_count); else n_pass++;
   endtask

   task automatic test_stall();
      ev_t so;
      clear_events();
      for (int i = 1; i <= 3; i++) send_byte(8'(i * 5), 1'b0);
      freeze = 1'b1; s_valid = 1'b1; s_data = 8'd20;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (s_ready !== 1'b0 || fill !== 3'd3)
            $display("FAIL stall_hold%0d: got ready %b fill %0d expected 0 3", c, s_ready, fill);
         else n_pass++;
      end
      freeze = 1'b0;
      for (int i = 4; i <= 8; i++) send_byte(8'(i * 5), 1'b0);
      // Freeze rises in the launch cycle: the commit still lands and the sum still completes.
      freeze = 1'b1; s_valid = 1'b1; s_data = 8'd99;
      repeat (6) tick();
      freeze = 1'b0; s_valid = 1'b0;
      so = (obs_s.size() > 0) ? obs_s[0] : '1;
      n_checks++;
      if (fill !== 3'd0) $display("FAIL stall_commit_freeze_fill: got %0d expected 0", fill); else n_pass++;
      n_checks++;
      if (obs_l.size() != 1 || obs_s.size() != 1 || so.v !== 64'd180)
         $display("FAIL stall_sum: got %0d launches %0d pulses sum %0d expected 1 1 180", obs_l.size(), obs_s.size(), so.v);
      else n_pass++;
   endtask

   task automatic test_reset_mid_fill();
      ev_t so;
      clear_events();
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
      send_byte(8'($urandom), 1'b0);
      send_byte(8'($urandom), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (dut_lanes !== 64'd0 || fill !== 3'd0 || vec_count !== '0)
         $display("FAIL midrst_state: got lanes %h fill %0d count %0d expected 0 0 0", dut_lanes, fill, vec_count);
      else n_pass++;
      idle(5);
      n_checks++;
      if (obs_s.size() != 0) $display("FAIL midrst_pending: got %0d sum_valid pulses expected 0", obs_s.size()); else n_pass++;
      clear_events();
      for (int i = 0; i < 8; i++) send_byte(8'd0, 1'b0);
      idle(6);
      so = (obs_s.size() > 0) ? obs_s[0] : '1;
      n_checks++;
      if (obs_l.size() != 1 || obs_s.size() != 1 || so.v !== 64'd0 || so !== ((exp_s.size() > 0) ? exp_s[0] : '1))
         $display("FAIL midrst_zero_vec: got %0d launches %0d pulses sum %0d expected 1 1 0", obs_l.size(), obs_s.size(), so.v);
      else n_pass++;
   endtask

   task automatic test_short_frame();
      ev_t lo, so;
      clear_events();
      send_byte(8'd5, 1'b0);
      send_byte(8'd10, 1'b0);
      send_byte(8'd15, 1'b1);
      idle(6);
`ifdef PACKER_LAST_PAD_EN
      lo = (obs_l.size() > 0) ? obs_l[0] : '1;
      so = (obs_s.size() > 0) ? obs_s[0] : '1;
      n_checks++;
      if (obs_l.size() != 1 || lo.v !== 64'h0000_0000_000F_0A05)
         $display("FAIL short_lanes: got %0d launches lanes %h expected 1 lanes 0f0a05", obs_l.size(), lo.v);
      else n_pass++;
      n_checks++;
      if (obs_s.size() != 1 || so.v !== 64'd30)
         $display("FAIL short_sum: got %0d pulses sum %0d expected 1 30", obs_s.size(), so.v);
      else n_pass++;
`else
      n_checks++;
      if (obs_l.size() != 0 || fill !== 3'd3)
         $display("FAIL short_ignored: got %0d launches fill %0d expected 0 3", obs_l.size(), fill);
      else n_pass++;
      for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0);
      idle(6);
      lo = (obs_l.size() > 0) ? obs_l[0] : '1;
      so = (obs_s.size() > 0) ? obs_s[0] : '1;
      n_checks++;
      if (obs_l.size() != 1 || lo !== ((exp_l.size() > 0) ? exp_l[0] : '0))
         $display("FAIL short_full_lanes: got %0d launches lanes %h expected 1", obs_l.size(), lo.v);
      else n_pass++;
      n_checks++;
      if (obs_s.size() != 1 || so !== ((exp_s.size() > 0) ? exp_s[0] : '0))
         $display("FAIL short_full_sum: got %0d pulses sum %0d expected 1", obs_s.size(), so.v);
      else n_pass++;
`endif
   endtask

   task automatic test_random();
      int errs = 0;
      clear_events();
      for (int c = 0; c < 300; c++) begin
         s_valid = ($urandom_range(3) != 0);
         freeze  = ($urandom_range(6) == 0);
         s_last  = ($urandom_range(9) == 0);
         s_data  = 8'($urandom);
         tick();
         n_checks++;
         if (fill !== 3'(m_bytes.size()) || s_ready !== (!freeze && !m_rst_q)) begin
            $display("FAIL rand_cycle%0d: got fill %0d ready %b expected %0d %b",
                     c, fill, s_ready, m_bytes.size(), !freeze && !m_rst_q);
         end else n_pass++;
      end
      freeze = 1'b0; s_last = 1'b0;
      idle(6);
      n_checks++;
      if (obs_l.size() != exp_l.size() || obs_s.size() != exp_s.size())
         $display("FAIL rand_event_count: got %0d/%0d expected %0d/%0d", obs_l.size(), obs_s.size(), exp_l.size(), exp_s.size());
      else n_pass++;
      foreach (exp_l[i]) if (i < obs_l.size() && obs_l[i] !== exp_l[i]) errs++;
      foreach (exp_s[i]) if (i < obs_s.size() && obs_s[i] !== exp_s[i]) errs++;
      n_checks++;
      if (errs != 0) $display("FAIL rand_events: got %0d differing launch/sum events expected 0", errs); else n_pass++;
      n_checks++;
      if (vec_count !== CNT_W'(m_count)) $display("FAIL rand_vec_count: got %0d expected %0d", vec_count, m_count); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_vector();
      test_back_to_back();
      test_stall();
      test_reset_mid_fill();
      test_short_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
